// File: rtl/fp_mult_pipe_if.sv
// Valid/ready handshake bundle for the pipelined floating-point multiplier.
// The slave modport is the multiplier side; the master modport is the producer/consumer side.
interface fp_mult_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 7
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         rnd_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, rnd_mode, out_ready,
    input  in_ready, out_valid, out, flags
  );

  modport slave (
    input  in_valid, a, b, rnd_mode, out_ready,
    output in_ready, out_valid, out, flags
  );
endinterface

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with RNE/truncate rounding, flush-to-zero
// subnormals and {invalid, overflow, underflow, inexact} flags carried with each result.
module fp_mult_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 7
) (
  input logic           clk,
  input logic           rst_n,
  fp_mult_pipe_if.slave bus
);
  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned SW = MAN_W + 1;
  localparam int unsigned PW = 2 * SW;
  localparam int unsigned EW = EXP_W + 2;

  localparam logic signed [EW-1:0] Bias   = EW'(2 ** (EXP_W - 1) - 1);
  localparam logic signed [EW-1:0] ExpMax = EW'(2 ** EXP_W - 1);

  // Operand class bit positions.
  localparam int unsigned ClsNan  = 2;
  localparam int unsigned ClsInf  = 1;
  localparam int unsigned ClsZero = 0;

  function automatic logic [2:0] classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    logic [2:0] c;
    c          = '0;
    c[ClsNan]  = (&e) & (|m);
    c[ClsInf]  = (&e) & ~(|m);
    c[ClsZero] = ~(|e);
    return c;
  endfunction

  // Global advance: every stage moves when the output slot is free or being drained.
  logic en;
  assign en           = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = en;

  // Stage 1 state
  logic             s1_valid_d, s1_valid_q;
  logic             s1_sign_d,  s1_sign_q;
  logic             s1_rnd_d,   s1_rnd_q;
  logic [EXP_W-1:0] s1_ea_d,    s1_ea_q;
  logic [EXP_W-1:0] s1_eb_d,    s1_eb_q;
  logic [SW-1:0]    s1_ma_d,    s1_ma_q;
  logic [SW-1:0]    s1_mb_d,    s1_mb_q;
  logic [2:0]       s1_cls_a_d, s1_cls_a_q;
  logic [2:0]       s1_cls_b_d, s1_cls_b_q;

  // Stage 2 state
  logic                 s2_valid_d, s2_valid_q;
  logic                 s2_sign_d,  s2_sign_q;
  logic                 s2_rnd_d,   s2_rnd_q;
  logic [PW-1:0]        s2_prod_d,  s2_prod_q;
  logic signed [EW-1:0] s2_esum_d,  s2_esum_q;
  logic                 s2_nan_d,   s2_nan_q;
  logic                 s2_inf_d,   s2_inf_q;
  logic                 s2_zero_d,  s2_zero_q;

  // Stage 3 (output) state
  logic         out_valid_d, out_valid_q;
  logic [W-1:0] out_d,       out_q;
  logic [3:0]   flags_d,     flags_q;

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.flags     = flags_q;

  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  assign a_exp = bus.a[W-2 -: EXP_W];
  assign b_exp = bus.b[W-2 -: EXP_W];
  assign a_man = bus.a[MAN_W-1:0];
  assign b_man = bus.b[MAN_W-1:0];

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_rnd_d   = s1_rnd_q;
    s1_ea_d    = s1_ea_q;
    s1_eb_d    = s1_eb_q;
    s1_ma_d    = s1_ma_q;
    s1_mb_d    = s1_mb_q;
    s1_cls_a_d = s1_cls_a_q;
    s1_cls_b_d = s1_cls_b_q;
    if (en) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_sign_d  = bus.a[W-1] ^ bus.b[W-1];
        s1_rnd_d   = bus.rnd_mode;
        s1_ea_d    = a_exp;
        s1_eb_d    = b_exp;
        s1_ma_d    = {1'b1, a_man};
        s1_mb_d    = {1'b1, b_man};
        s1_cls_a_d = classify(a_exp, a_man);
        s1_cls_b_d = classify(b_exp, b_man);
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_rnd_d   = s2_rnd_q;
    s2_prod_d  = s2_prod_q;
    s2_esum_d  = s2_esum_q;
    s2_nan_d   = s2_nan_q;
    s2_inf_d   = s2_inf_q;
    s2_zero_d  = s2_zero_q;
    if (en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_d = s1_sign_q;
        s2_rnd_d  = s1_rnd_q;
        s2_prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);
        s2_esum_d = $signed({2'b00, s1_ea_q}) + $signed({2'b00, s1_eb_q}) - Bias;
        s2_nan_d  = s1_cls_a_q[ClsNan] | s1_cls_b_q[ClsNan]
                  | (s1_cls_a_q[ClsInf] & s1_cls_b_q[ClsZero])
                  | (s1_cls_b_q[ClsInf] & s1_cls_a_q[ClsZero]);
        s2_inf_d  = s1_cls_a_q[ClsInf] | s1_cls_b_q[ClsInf];
        s2_zero_d = s1_cls_a_q[ClsZero] | s1_cls_b_q[ClsZero];
      end
    end
  end

  // Normalise and round the stage-2 product.
  logic                 norm;
  logic [PW-2:0]        prod_n;
  logic [MAN_W-1:0]     man_t;
  logic                 guard;
  logic                 sticky;
  logic                 round_up;
  logic [MAN_W:0]       man_r;
  logic signed [EW-1:0] exp_r;
  logic                 ovf;
  logic                 unf;

  always_comb begin
    norm     = s2_prod_q[PW-1];
    // Align so the leading 1 sits just above bit PW-2 and is dropped.
    prod_n   = norm ? s2_prod_q[PW-2:0] : {s2_prod_q[PW-3:0], 1'b0};
    man_t    = prod_n[PW-2 -: MAN_W];
    guard    = prod_n[PW-2-MAN_W];
    sticky   = |prod_n[PW-3-MAN_W:0];
    round_up = ~s2_rnd_q & guard & (man_t[0] | sticky);
    man_r    = {1'b0, man_t} + {{MAN_W{1'b0}}, round_up};
    // A carry out of the mantissa leaves man_r[MAN_W-1:0] at zero, so only the exponent moves.
    exp_r    = s2_esum_q + $signed({{(EW-1){1'b0}}, norm})
             + $signed({{(EW-1){1'b0}}, man_r[MAN_W]});
    ovf      = ~exp_r[EW-1] & (exp_r >= ExpMax);
    unf      = exp_r[EW-1] | (exp_r == '0);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    flags_d     = flags_q;
    if (en) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        flags_d = '0;
        if (s2_nan_q) begin
          out_d   = {s2_sign_q, {EXP_W{1'b1}}, {{(MAN_W-1){1'b0}}, 1'b1}};
          flags_d = 4'b1000;
        end else if (s2_inf_q) begin
          out_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s2_zero_q) begin
          out_d = {s2_sign_q, {(W-1){1'b0}}};
        end else if (ovf) begin
          flags_d = 4'b0101;
          if (s2_rnd_q) begin
            out_d = {s2_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
          end else begin
            out_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          end
        end else if (unf) begin
          out_d   = {s2_sign_q, {(W-1){1'b0}}};
          flags_d = 4'b0011;
        end else begin
          out_d   = {s2_sign_q, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
          flags_d = {3'b000, guard | sticky};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_rnd_q    <= 1'b0;
      s1_ea_q     <= '0;
      s1_eb_q     <= '0;
      s1_ma_q     <= '0;
      s1_mb_q     <= '0;
      s1_cls_a_q  <= '0;
      s1_cls_b_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_rnd_q    <= 1'b0;
      s2_prod_q   <= '0;
      s2_esum_q   <= '0;
      s2_nan_q    <= 1'b0;
      s2_inf_q    <= 1'b0;
      s2_zero_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_rnd_q    <= s1_rnd_d;
      s1_ea_q     <= s1_ea_d;
      s1_eb_q     <= s1_eb_d;
      s1_ma_q     <= s1_ma_d;
      s1_mb_q     <= s1_mb_d;
      s1_cls_a_q  <= s1_cls_a_d;
      s1_cls_b_q  <= s1_cls_b_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_rnd_q    <= s2_rnd_d;
      s2_prod_q   <= s2_prod_d;
      s2_esum_q   <= s2_esum_d;
      s2_nan_q    <= s2_nan_d;
      s2_inf_q    <= s2_inf_d;
      s2_zero_q   <= s2_zero_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
    end
  end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed-vector bench for fp_mult_pipe (bfloat16 configuration): latency, rounding,
// specials, streaming under random backpressure and mid-flight reset.
module tb_fp_mult_pipe;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 7;
  localparam int NVEC = 14;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        m;
    logic [15:0] o;
    logic [3:0]  f;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[NVEC];

  fp_mult_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Single op on an idle pipe with the consumer always ready.
  task automatic run_op(input string tag, input vec_t v);
    int lat;
    @(negedge clk);
    bus.a         = v.a;
    bus.b         = v.b;
    bus.rnd_mode  = v.m;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat++;
    end while (!bus.out_valid && lat < 10);
    check_eq({tag, "_lat"}, lat, 3);
    check_eq({tag, "_out"}, bus.out, v.o);
    check_eq({tag, "_flg"}, bus.flags, v.f);
  endtask

  initial begin
    int   sent, got, stale;
    logic stalled;
    logic [15:0] held_out;
    logic [3:0]  held_flg;

    vecs[0]  = '{16'h3FC0, 16'h4000, 1'b0, 16'h4040, 4'b0000};
    vecs[1]  = '{16'h3F85, 16'h3FC0, 1'b0, 16'h3FC8, 4'b0001};
    vecs[2]  = '{16'h3F85, 16'h3FC0, 1'b1, 16'h3FC7, 4'b0001};
    vecs[3]  = '{16'h3F83, 16'h3FC0, 1'b0, 16'h3FC4, 4'b0001};
    vecs[4]  = '{16'h7F00, 16'h7F00, 1'b0, 16'h7F80, 4'b0101};
    vecs[5]  = '{16'h7F00, 16'h7F00, 1'b1, 16'h7F7F, 4'b0101};
    vecs[6]  = '{16'h0080, 16'h0080, 1'b0, 16'h0000, 4'b0011};
    vecs[7]  = '{16'h7F80, 16'h0000, 1'b0, 16'h7F81, 4'b1000};
    vecs[8]  = '{16'hFF80, 16'h3F80, 1'b0, 16'hFF80, 4'b0000};
    vecs[9]  = '{16'h7FC0, 16'h3F80, 1'b0, 16'h7F81, 4'b1000};
    vecs[10] = '{16'h0001, 16'h4000, 1'b0, 16'h0000, 4'b0000};
    vecs[11] = '{16'hBFC0, 16'h4000, 1'b0, 16'hC040, 4'b0000};
    // 146*224 = 0x7FC0: rounds up through the mantissa carry into the next binade.
    vecs[12] = '{16'h3F92, 16'h3FE0, 1'b0, 16'h4000, 4'b0001};
    vecs[13] = '{16'h3F92, 16'h3FE0, 1'b1, 16'h3FFF, 4'b0001};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.rnd_mode  = 1'b0;
    bus.out_ready = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_valid", bus.out_valid, 0);
    check_eq("rst_out", bus.out, 0);
    check_eq("rst_flg", bus.flags, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Streaming with random backpressure, first ten vectors in order.
    @(negedge clk);
    bus.out_ready = 1'b1;
    sent = 0;
    got = 0;
    stalled = 1'b0;
    held_out = '0;
    held_flg = '0;
    for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        check_eq("hold_valid", bus.out_valid, 1);
        check_eq("hold_out", bus.out, held_out);
        check_eq("hold_flg", bus.flags, held_flg);
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.in_valid  = (sent < 10);
      if (sent < 10) begin
        bus.a        = vecs[sent].a;
        bus.b        = vecs[sent].b;
        bus.rnd_mode = vecs[sent].m;
      end
      #1;
      check_eq("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        check_eq($sformatf("strm%0d_out", got), bus.out, vecs[got].o);
        check_eq($sformatf("strm%0d_flg", got), bus.flags, vecs[got].f);
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      stalled  = bus.out_valid && !bus.out_ready;
      held_out = bus.out;
      held_flg = bus.flags;
    end
    check_eq("strm_count", got, 10);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check_eq("strm_extra", stale, 0);

    // Reset with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = vecs[1 + i].a;
      bus.b        = vecs[1 + i].b;
      bus.rnd_mode = vecs[1 + i].m;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check_eq("pre_rst_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", bus.out_valid, 0);
    check_eq("mid_rst_out", bus.out, 0);
    check_eq("mid_rst_flg", bus.flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check_eq("post_rst_stale", stale, 0);
    run_op("post_rst", vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
